// File: rtl/cart_loader.sv
// cart_loader
//   Loads PRG/CHR images into the cartridge emulator over a UART link.
//   The host sends serial 8N1 frames carrying a packet:
//     0xA5, TARGET (0x00 = PRG, 0x01 = CHR), LEN_LO, LEN_HI, LEN payload bytes, CSUM
//   where CSUM is the XOR of all payload bytes. Each payload byte becomes a
//   one-cycle write strobe on the selected memory port. The console is held in
//   reset through busy while a packet is in flight.
//
// Ports
//   clk_in      system clock (single clock domain)
//   rst_n_in    synchronous active-low reset
//   rx_in       UART receive line, asynchronous, idles high
//   addr_out    write byte address, relative to the start of the selected memory
//   data_out    write data
//   prg_we_out  one-cycle PRG write strobe
//   chr_we_out  one-cycle CHR write strobe
//   busy_out    high from target accepted until packet end (OR into CPU reset)
//   done_out    one-cycle pulse: packet finished with a good checksum
//   err_out     sticky error, cleared when the next magic byte is accepted
module cart_loader #(
    parameter int BAUD_DIV  = 217,
    parameter int TIMEOUT   = 2500000,
    parameter int PRG_BYTES = 32768,
    parameter int CHR_BYTES = 8192
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rx_in,
    output logic [14:0] addr_out,
    output logic [7:0]  data_out,
    output logic        prg_we_out,
    output logic        chr_we_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [16:0] PRG_CAP = 17'(PRG_BYTES);
    localparam logic [16:0] CHR_CAP = 17'(CHR_BYTES);
    localparam logic [7:0]  MAGIC   = 8'hA5;

    // ------------------------------------------------------------------
    // Input synchroniser; rx_d is one more stage so a falling edge can be
    // seen on fully synchronised samples.
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_d;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic             byte_valid, byte_valid_nxt;
    logic             frame_err, frame_err_nxt;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rx_state   <= RX_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            rx_byte    <= rx_byte_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        rx_state_nxt   = rx_state;
        baud_cnt_nxt   = baud_cnt + 1'b1;
        bit_idx_nxt    = bit_idx;
        rx_byte_nxt    = rx_byte;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                baud_cnt_nxt = '0;
                if (rx_d && !rx_s2) begin
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects glitches without flagging an error.
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nxt = '0;
                    rx_byte_nxt  = {rx_s2, rx_byte[7:1]};
                    bit_idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nxt   = '0;
                    rx_state_nxt   = RX_IDLE;
                    byte_valid_nxt = rx_s2;
                    frame_err_nxt  = !rx_s2;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_IDLE,
        P_TARGET,
        P_LEN_LO,
        P_LEN_HI,
        P_DATA,
        P_CSUM
    } pk_state_t;

    pk_state_t        pk_state, pk_state_nxt;
    logic             tgt_chr, tgt_chr_nxt;
    logic [7:0]       len_lo, len_lo_nxt;
    logic [15:0]      len, len_nxt;
    logic [15:0]      wr_cnt, wr_cnt_nxt;
    logic [7:0]       csum, csum_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [14:0]      addr_nxt;
    logic [7:0]       data_nxt;
    logic             prg_we_nxt, chr_we_nxt, busy_nxt, done_nxt, err_nxt;

    logic [15:0] len_full;
    logic [16:0] cap;
    logic [15:0] wr_cnt_inc;

    assign len_full   = {rx_byte, len_lo};
    assign cap        = tgt_chr ? CHR_CAP : PRG_CAP;
    assign wr_cnt_inc = wr_cnt + 16'd1;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pk_state   <= P_IDLE;
            tgt_chr    <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            wr_cnt     <= '0;
            csum       <= '0;
            tmo_cnt    <= '0;
            addr_out   <= '0;
            data_out   <= '0;
            prg_we_out <= 1'b0;
            chr_we_out <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            pk_state   <= pk_state_nxt;
            tgt_chr    <= tgt_chr_nxt;
            len_lo     <= len_lo_nxt;
            len        <= len_nxt;
            wr_cnt     <= wr_cnt_nxt;
            csum       <= csum_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            addr_out   <= addr_nxt;
            data_out   <= data_nxt;
            prg_we_out <= prg_we_nxt;
            chr_we_out <= chr_we_nxt;
            busy_out   <= busy_nxt;
            done_out   <= done_nxt;
            err_out    <= err_nxt;
        end
    end

    always_comb begin
        pk_state_nxt = pk_state;
        tgt_chr_nxt  = tgt_chr;
        len_lo_nxt   = len_lo;
        len_nxt      = len;
        wr_cnt_nxt   = wr_cnt;
        csum_nxt     = csum;
        addr_nxt     = addr_out;
        data_nxt     = data_out;
        prg_we_nxt   = 1'b0;
        chr_we_nxt   = 1'b0;
        busy_nxt     = busy_out;
        done_nxt     = 1'b0;
        err_nxt      = err_out;
        // The idle counter only runs while a packet is open.
        tmo_cnt_nxt  = (pk_state == P_IDLE || byte_valid) ? '0 : tmo_cnt + 1'b1;

        if (frame_err) begin
            pk_state_nxt = P_IDLE;
            err_nxt      = 1'b1;
            busy_nxt     = 1'b0;
        end else if (byte_valid) begin
            case (pk_state)
                P_IDLE: begin
                    if (rx_byte == MAGIC) begin
                        pk_state_nxt = P_TARGET;
                        err_nxt      = 1'b0;
                    end
                end
                P_TARGET: begin
                    if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
                        pk_state_nxt = P_LEN_LO;
                        tgt_chr_nxt  = rx_byte[0];
                        busy_nxt     = 1'b1;
                        wr_cnt_nxt   = '0;
                        csum_nxt     = '0;
                    end else begin
                        pk_state_nxt = P_IDLE;
                        err_nxt      = 1'b1;
                    end
                end
                P_LEN_LO: begin
                    len_lo_nxt   = rx_byte;
                    pk_state_nxt = P_LEN_HI;
                end
                P_LEN_HI: begin
                    len_nxt = len_full;
                    if ({1'b0, len_full} > cap) begin
                        pk_state_nxt = P_IDLE;
                        err_nxt      = 1'b1;
                        busy_nxt     = 1'b0;
                    end else if (len_full == 16'd0) begin
                        pk_state_nxt = P_CSUM;
                    end else begin
                        pk_state_nxt = P_DATA;
                    end
                end
                P_DATA: begin
                    addr_nxt   = wr_cnt[14:0];
                    data_nxt   = rx_byte;
                    prg_we_nxt = !tgt_chr;
                    chr_we_nxt = tgt_chr;
                    csum_nxt   = csum ^ rx_byte;
                    wr_cnt_nxt = wr_cnt_inc;
                    if (wr_cnt_inc == len) begin
                        pk_state_nxt = P_CSUM;
                    end
                end
                P_CSUM: begin
                    pk_state_nxt = P_IDLE;
                    busy_nxt     = 1'b0;
                    if (rx_byte == csum) begin
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    pk_state_nxt = P_IDLE;
                end
            endcase
        end else if (pk_state != P_IDLE && tmo_cnt == TMO_LAST) begin
            // Host went silent mid-packet; give the console back.
            pk_state_nxt = P_IDLE;
            err_nxt      = 1'b1;
            busy_nxt     = 1'b0;
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: randomized packets through a serial driver, a
// packet-level reference model filling an expected-event queue, and a
// monitor that pops and compares on every DUT output event.
module tb_cart_loader;

    localparam int BD  = 8;
    localparam int TMO = 600;
    localparam int PRG = 64;
    localparam int CHR = 32;

    localparam int K_PRG  = 0;
    localparam int K_CHR  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rx_in = 1'b1;
    logic [14:0] addr_out;
    logic [7:0]  data_out;
    logic        prg_we_out, chr_we_out, busy_out, done_out, err_out;

    cart_loader #(
        .BAUD_DIV (BD),
        .TIMEOUT  (TMO),
        .PRG_BYTES(PRG),
        .CHR_BYTES(CHR)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rx_in     (rx_in),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .prg_we_out(prg_we_out),
        .chr_we_out(chr_we_out),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .err_out   (err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pl[$];
    int         total = 0;
    int         bad = 0;
    logic       prev_err = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, req);
        end
    endtask

    task automatic push_ev(input int k, input int a, input int d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int k, input int a, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d addr 'h%0h data 'h%0h, expected none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            if (e.kind == K_PRG || e.kind == K_CHR) begin
                check("write_addr", a, e.addr);
                check("write_data", d, e.data);
                check("busy_during_write", int'(busy_out), 1);
            end
        end
    endtask

    // Monitor: outputs sampled on the falling edge.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if ((prg_we_out || chr_we_out) && done_out) begin
                total++;
                bad++;
                $display("FAIL strobe_with_done: got we and done together, expected exclusive");
            end
            if (prg_we_out && chr_we_out) begin
                total++;
                bad++;
                $display("FAIL dual_strobe: got prg and chr together, expected one");
            end
            if (prg_we_out) pop_check(K_PRG, int'(addr_out), int'(data_out));
            if (chr_we_out) pop_check(K_CHR, int'(addr_out), int'(data_out));
            if (done_out)   pop_check(K_DONE, 0, 0);
            if (err_out && !prev_err) pop_check(K_ERR, 0, 0);
        end
        prev_err <= err_out;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk_in);
        rx_in = 1'b0;
        repeat (BD) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (BD) @(negedge clk_in);
        end
        rx_in = stop_ok;
        repeat (BD) @(negedge clk_in);
        rx_in = 1'b1;
        repeat (BD * $urandom_range(0, 3) + 1) @(negedge clk_in);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk_in);
    endtask

    // Reference model at packet level: header legality, capacity, then one
    // write per payload byte and a final verdict from the XOR of the payload.
    task automatic run_packet(input logic [7:0] tgt, input int len, input int csum_ovr);
        logic [7:0] x;
        logic [7:0] c;
        logic [15:0] l16;
        int cap;
        l16 = 16'(len);
        x = 8'h00;
        foreach (pl[i]) x = x ^ pl[i];
        if (tgt > 8'd1) begin
            push_ev(K_ERR, 0, 0);
            send_byte(8'hA5, 1'b1);
            send_byte(tgt, 1'b1);
        end else begin
            cap = (tgt == 8'd1) ? CHR : PRG;
            if (len > cap) begin
                push_ev(K_ERR, 0, 0);
                send_byte(8'hA5, 1'b1);
                send_byte(tgt, 1'b1);
                send_byte(l16[7:0], 1'b1);
                send_byte(l16[15:8], 1'b1);
            end else begin
                for (int i = 0; i < len; i++)
                    push_ev((tgt == 8'd1) ? K_CHR : K_PRG, i, int'(pl[i]));
                c = (csum_ovr < 0) ? x : 8'(csum_ovr);
                push_ev((c == x) ? K_DONE : K_ERR, 0, 0);
                send_byte(8'hA5, 1'b1);
                send_byte(tgt, 1'b1);
                send_byte(l16[7:0], 1'b1);
                send_byte(l16[15:8], 1'b1);
                for (int i = 0; i < len; i++) send_byte(pl[i], 1'b1);
                send_byte(c, 1'b1);
            end
        end
        wait_drain(4000);
    endtask

    initial begin
        int len;
        logic [7:0] tgt;

        // Reset held with a toggling line: everything quiet.
        rst_n_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rx_in = 1'($urandom_range(0, 1));
            @(negedge clk_in);
            if (i % 8 == 7)
                check("reset_outputs", int'({addr_out, data_out, prg_we_out, chr_we_out,
                                             busy_out, done_out, err_out}), 0);
        end
        rx_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (100) @(negedge clk_in);
        check("post_reset_busy", int'(busy_out), 0);
        check("post_reset_err", int'(err_out), 0);

        // Non-magic bytes in IDLE are ignored.
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_drain(100);
        check("junk_busy", int'(busy_out), 0);

        // PRG load, checksum computed from the payload.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_packet(8'h00, 4, -1);
        check("prg_err", int'(err_out), 0);
        check("prg_busy", int'(busy_out), 0);

        // Full CHR at the bench's capacity.
        pl.delete();
        for (int i = 0; i < CHR; i++) pl.push_back(8'(i));
        run_packet(8'h01, CHR, -1);
        check("chr_full_err", int'(err_out), 0);

        // Bad checksum.
        pl = '{8'h5A};
        run_packet(8'h00, 1, 0);
        check("bad_csum_err", int'(err_out), 1);
        check("bad_csum_busy", int'(busy_out), 0);

        // Oversize CHR, bad target, oversize by one.
        pl.delete();
        run_packet(8'h01, 16'h2001, -1);
        check("oversize_err", int'(err_out), 1);
        check("oversize_busy", int'(busy_out), 0);
        run_packet(8'h07, 0, -1);
        check("bad_target_err", int'(err_out), 1);
        run_packet(8'h00, PRG + 1, -1);
        check("prg_cap_plus1_err", int'(err_out), 1);

        // Zero length, then full PRG.
        run_packet(8'h00, 0, -1);
        check("zero_len_err", int'(err_out), 0);
        for (int i = 0; i < PRG; i++) pl.push_back(8'($urandom_range(0, 255)));
        run_packet(8'h00, PRG, -1);
        check("prg_full_err", int'(err_out), 0);

        // Random packets, some with a corrupted checksum.
        for (int n = 0; n < 6; n++) begin
            tgt = 8'($urandom_range(0, 1));
            len = $urandom_range(0, (tgt == 8'd1) ? CHR : PRG);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            run_packet(tgt, len, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1);
            check("random_busy", int'(busy_out), 0);
        end

        // Framing error in the middle of the payload.
        push_ev(K_PRG, 0, 8'h11);
        push_ev(K_PRG, 1, 8'h22);
        push_ev(K_ERR, 0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_drain(1000);
        check("framing_busy", int'(busy_out), 0);
        check("framing_err", int'(err_out), 1);
        pl = '{8'hC3, 8'h3C};
        run_packet(8'h00, 2, -1);
        check("after_framing_err", int'(err_out), 0);

        // Header then silence.
        push_ev(K_ERR, 0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TMO / 2) @(negedge clk_in);
        check("pre_timeout_err", int'(err_out), 0);
        check("pre_timeout_busy", int'(busy_out), 1);
        wait_drain(TMO + 200);
        check("timeout_err", int'(err_out), 1);
        check("timeout_busy", int'(busy_out), 0);

        // Reset in the middle of a transfer.
        push_ev(K_PRG, 0, 8'h77);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h77, 1'b1);
        wait_drain(500);
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("midreset_outputs", int'({addr_out, data_out, prg_we_out, chr_we_out,
                                        busy_out, done_out, err_out}), 0);
        rst_n_in = 1'b1;
        repeat (2 * TMO) @(negedge clk_in);
        check("after_midreset_err", int'(err_out), 0);
        check("after_midreset_busy", int'(busy_out), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
